// File: rtl/thor2022_icache_fill.sv
// Instruction-cache line-fill controller: confirms a miss, fetches the 64-byte line as
// four 128-bit beats, writes the tag and maintains the per-way line-valid bits.
module thor2022_icache_fill #(
  parameter int LINES = 128,
  parameter int WAYS  = 4,
  parameter int AWID  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AWID-1:0]  ip,
  input  logic             ihit,
  input  logic             invall,
  input  logic             invline,
  input  logic [AWID-1:0]  invadr,
  output logic [LINES-1:0] valid [0:WAYS-1],
  output logic             busy,
  output logic             mem_req,
  output logic [AWID-1:0]  mem_adr,
  input  logic             mem_ack,
  input  logic [127:0]     mem_dat,
  output logic             wr,
  output logic [1:0]       wr_way,
  output logic [AWID-1:0]  wr_adr,
  output logic [127:0]     wr_dat,
  output logic             tag_wr,
  output logic [1:0]       tag_way,
  output logic [AWID-7:0]  tag_val,
  output logic             fill_done
);
  localparam int IDXW = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, SETTLE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      beat_reg, beat_next;
  logic [1:0]      cnt_reg, cnt_next;
  logic [AWID-7:0] line_reg, line_next;
  logic [AWID-1:0] mem_adr_reg, mem_adr_next;
  logic            mem_req_reg, mem_req_next;
  logic [1:0]      wr_way_reg, wr_way_next;
  logic            abort_reg, abort_next;
  logic [7:0]      lfsr_reg, lfsr_next;
  logic [AWID-7:0] prev_line_reg, prev_line_next;
  logic            miss_first_reg, miss_first_next;
  logic            set_valid;
  logic [1:0]      sel_way;
  logic [WAYS-1:0] idx_valid;

  logic [AWID-7:0] ip_line;
  logic [IDXW-1:0] ip_idx, inv_idx, fill_idx;
  logic            inv_hit;
  logic            unused_bits;

  assign ip_line  = ip[AWID-1:6];
  assign ip_idx   = ip[6+IDXW-1:6];
  assign inv_idx  = invadr[6+IDXW-1:6];
  assign fill_idx = line_reg[IDXW-1:0];
  assign inv_hit  = invall || (invline && inv_idx == fill_idx);
  assign unused_bits = ^{ip[5:0], invadr[5:0], invadr[AWID-1:6+IDXW]};

  // Invalidation is applied after the fill set so it wins on the same bit
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [LINES-1:0] bits_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bits_reg <= '0;
        end else if (invall) begin
          bits_reg <= '0;
        end else begin
          if (set_valid && wr_way_reg == 2'(gi))
            bits_reg[fill_idx] <= 1'b1;
          if (invline)
            bits_reg[inv_idx] <= 1'b0;
        end
      end
      assign valid[gi]     = bits_reg;
      assign idx_valid[gi] = bits_reg[ip_idx];
    end
  endgenerate

  // Lowest free way wins; a fully occupied set falls back to the LFSR
  always_comb begin
    sel_way = lfsr_reg[1:0];
    for (int w = WAYS-1; w >= 0; w--)
      if (!idx_valid[w]) sel_way = 2'(w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_reg       <= 2'd0;
      cnt_reg        <= 2'd0;
      line_reg       <= '0;
      mem_adr_reg    <= '0;
      mem_req_reg    <= 1'b0;
      wr_way_reg     <= 2'd0;
      abort_reg      <= 1'b0;
      lfsr_reg       <= 8'h01;
      prev_line_reg  <= '0;
      miss_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      cnt_reg        <= cnt_next;
      line_reg       <= line_next;
      mem_adr_reg    <= mem_adr_next;
      mem_req_reg    <= mem_req_next;
      wr_way_reg     <= wr_way_next;
      abort_reg      <= abort_next;
      lfsr_reg       <= lfsr_next;
      prev_line_reg  <= prev_line_next;
      miss_first_reg <= miss_first_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    cnt_next        = cnt_reg;
    line_next       = line_reg;
    mem_adr_next    = mem_adr_reg;
    mem_req_next    = mem_req_reg;
    wr_way_next     = wr_way_reg;
    abort_next      = abort_reg;
    prev_line_next  = ip_line;
    miss_first_next = 1'b0;
    lfsr_next       = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    set_valid       = 1'b0;
    wr              = 1'b0;
    tag_wr          = 1'b0;
    fill_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // First miss sample arms the detector; a second one on the same line confirms it
        miss_first_next = ~ihit;
        if (!ihit && miss_first_reg && ip_line == prev_line_reg) begin
          line_next       = ip_line;
          wr_way_next     = sel_way;
          mem_adr_next    = {ip_line, 6'b0};
          mem_req_next    = 1'b1;
          beat_next       = 2'd0;
          abort_next      = 1'b0;
          miss_first_next = 1'b0;
          state_next      = FETCH;
        end
      end
      FETCH: begin
        wr = mem_ack;
        if (inv_hit) abort_next = 1'b1;
        if (mem_ack) begin
          if (beat_reg == 2'd3) begin
            mem_req_next = 1'b0;
            state_next   = UPDATE;
          end else begin
            beat_next    = beat_reg + 2'd1;
            mem_adr_next = mem_adr_reg + AWID'(16);
          end
        end
      end
      UPDATE: begin
        tag_wr    = 1'b1;
        fill_done = 1'b1;
        set_valid = ~abort_reg;
        if (inv_hit) abort_next = 1'b1;
        cnt_next   = 2'd2;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt_reg == 2'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign mem_req = mem_req_reg;
  assign mem_adr = mem_adr_reg;
  assign wr_way  = wr_way_reg;
  assign wr_adr  = mem_adr_reg;
  assign wr_dat  = mem_dat;
  assign tag_way = wr_way_reg;
  assign tag_val = line_reg;

endmodule

// File: tb/tb_thor2022_icache_fill.sv
// Bench for the icache fill controller: directed table of fills, hand-written corner
// sequences and randomized fills checked against a line/way occupancy model.
module tb_thor2022_icache_fill;
  localparam int LINES = 128;
  localparam int WAYS  = 4;
  localparam int AWID  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [AWID-1:0]  ip;
  logic             ihit;
  logic             invall;
  logic             invline;
  logic [AWID-1:0]  invadr;
  logic [LINES-1:0] valid [0:WAYS-1];
  logic             busy;
  logic             mem_req;
  logic [AWID-1:0]  mem_adr;
  logic             mem_ack;
  logic [127:0]     mem_dat;
  logic             wr;
  logic [1:0]       wr_way;
  logic [AWID-1:0]  wr_adr;
  logic [127:0]     wr_dat;
  logic             tag_wr;
  logic [1:0]       tag_way;
  logic [AWID-7:0]  tag_val;
  logic             fill_done;

  thor2022_icache_fill #(.LINES(LINES), .WAYS(WAYS), .AWID(AWID)) dut (
    .clk(clk), .rst(rst), .ip(ip), .ihit(ihit), .invall(invall), .invline(invline),
    .invadr(invadr), .valid(valid), .busy(busy), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_dat(mem_dat), .wr(wr), .wr_way(wr_way), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .tag_wr(tag_wr), .tag_way(tag_way), .tag_val(tag_val),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          d0, d1, d2, d3;
    int          inv_kind;   // 0 none, 1 invall, 2 invline same index, 3 invline next index
    int          inv_beat;
    int          exp_way;    // -1: take the way from the occupancy model
    logic [25:0] exp_tag;
  } vec_t;

  vec_t             tbl [9];
  logic [LINES-1:0] valid_m [WAYS];
  logic [7:0]       lfsr_m = 8'h01;
  int               wr_pulses = 0;
  int               total = 0;
  int               bad = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) lfsr_m <= 8'h01;
    else     lfsr_m <= lfsr_step(lfsr_m);

  always @(negedge clk)
    if (wr === 1'b1) wr_pulses <= wr_pulses + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_valid();
    for (int w = 0; w < WAYS; w++)
      chk($sformatf("valid_way%0d", w), valid[w], valid_m[w]);
  endfunction

  function automatic int model_way(input int idx);
    for (int w = 0; w < WAYS; w++)
      if (!valid_m[w][idx]) return w;
    return int'(lfsr_m[1:0]);
  endfunction

  task automatic run_fill(input vec_t v);
    logic [31:0]  line;
    logic [127:0] dat;
    int           dl [4];
    int           way;
    int           idx;
    int           wr0;
    logic         aborted;
    line    = {v.addr[31:6], 6'b0};
    idx     = int'(v.addr[12:6]);
    dl      = '{v.d0, v.d1, v.d2, v.d3};
    aborted = 1'b0;
    wr0     = wr_pulses;
    ip = v.addr; ihit = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("miss_req_early", mem_req, 0);
    way = (v.exp_way >= 0) ? v.exp_way : model_way(idx);
    @(posedge clk); #1;
    ihit = 1'b1;
    chk("req_rise", mem_req, 1);
    chk("fill_busy", busy, 1);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < dl[b]; k++) begin
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wait_req", mem_req, 1);
        chk("wait_adr", mem_adr, line + 32'(16 * b));
        chk("wait_wr", wr, 0);
        @(posedge clk); #1;
      end
      dat = {$urandom, $urandom, $urandom, $urandom};
      mem_ack = 1'b1; mem_dat = dat;
      if (b == v.inv_beat) begin
        case (v.inv_kind)
          1: invall = 1'b1;
          2: begin invline = 1'b1; invadr = line + 32'd4; end
          3: begin invline = 1'b1; invadr = line + 32'd64; end
          default: ;
        endcase
      end
      @(negedge clk);
      chk("beat_adr", mem_adr, line + 32'(16 * b));
      chk("beat_req", mem_req, 1);
      chk("wr", wr, 1);
      chk("wr_adr", wr_adr, line + 32'(16 * b));
      chk("wr_dat", wr_dat, dat);
      chk("wr_way", wr_way, way);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (b == v.inv_beat && v.inv_kind != 0) begin
        case (v.inv_kind)
          1: begin for (int w = 0; w < WAYS; w++) valid_m[w] = '0; aborted = 1'b1; end
          2: begin for (int w = 0; w < WAYS; w++) valid_m[w][idx] = 1'b0; aborted = 1'b1; end
          default: for (int w = 0; w < WAYS; w++) valid_m[w][(idx + 1) % LINES] = 1'b0;
        endcase
        invall = 1'b0; invline = 1'b0;
        chk_valid();
      end
    end
    @(negedge clk);
    chk("tag_wr", tag_wr, 1);
    chk("fill_done", fill_done, 1);
    chk("tag_val", tag_val, v.exp_tag);
    chk("tag_way", tag_way, way);
    chk("upd_req", mem_req, 0);
    chk("upd_wr", wr, 0);
    @(posedge clk); #1;
    if (!aborted) valid_m[way][idx] = 1'b1;
    chk_valid();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("settle_busy", busy, 1);
      chk("settle_tag_wr", tag_wr, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_busy", busy, 0);
    chk("wr_pulses", wr_pulses - wr0, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        rv;
    logic [7:0]  nx;
    int          guard;
    int          ridx [4];
    logic [31:0] a;
    ridx = '{5, 6, 7, 9};
    tbl[0] = '{32'h0000_1040, 0, 0, 0, 0, 0, 0, 0, 26'h41};
    tbl[1] = '{32'h0000_0140, 0, 0, 0, 0, 0, 0, 0, 26'h5};
    tbl[2] = '{32'h0000_2140, 0, 0, 0, 0, 0, 0, 1, 26'h85};
    tbl[3] = '{32'h0000_4140, 0, 0, 0, 0, 0, 0, 2, 26'h105};
    tbl[4] = '{32'h0000_6140, 0, 0, 0, 0, 0, 0, 3, 26'h185};
    tbl[5] = '{32'h0000_3080, 2, 2, 0, 2, 0, 0, 0, 26'hC2};
    tbl[6] = '{32'h0000_10C0, 0, 0, 0, 0, 1, 1, 0, 26'h43};
    tbl[7] = '{32'h0000_1100, 0, 0, 0, 0, 2, 2, 0, 26'h44};
    tbl[8] = '{32'h0000_1140, 0, 0, 0, 0, 3, 0, 0, 26'h45};
    for (int w = 0; w < WAYS; w++) valid_m[w] = '0;
    ip = '0; ihit = 1'b1; invall = 1'b0; invline = 1'b0; invadr = '0;
    mem_ack = 1'b0; mem_dat = '0;

    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_way", wr_way, 0);
    chk("rst_tag_val", tag_val, 0);
    chk("rst_fill_done", fill_done, 0);
    chk_valid();
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_fill(tbl[i]);

    // Set at index 5 is full: wait until the LFSR will show 2 in the miss cycle
    nx = lfsr_step(lfsr_m);
    guard = 0;
    while (nx[1:0] != 2'd2 && guard < 300) begin
      @(posedge clk); #1;
      nx = lfsr_step(lfsr_m);
      guard++;
    end
    chk("lfsr_wait_bound", guard < 300, 1);
    run_fill('{32'h0000_8140, 0, 0, 0, 0, 0, 0, 2, 26'h205});

    for (int i = 5; i < 9; i++) run_fill(tbl[i]);

    // A line change every cycle must never confirm a miss
    ihit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ip = 32'h0000_7000 + 32'(64 * k);
      @(negedge clk);
      chk("chg_busy", busy, 0);
      chk("chg_req", mem_req, 0);
      @(posedge clk); #1;
    end
    run_fill('{32'h0000_1180, 0, 0, 0, 0, 0, 0, -1, 26'h46});

    for (int n = 0; n < 40; n++) begin
      int r;
      a = (32'($urandom_range(0, 15)) << 13) | (32'(ridx[$urandom_range(0, 3)]) << 6)
          | 32'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      rv = '{a, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), (r < 3) ? r + 1 : 0, $urandom_range(0, 3), -1, a[31:6]};
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(posedge clk); #1;
      end
      run_fill(rv);
    end

    // Reset in the middle of beat 2 aborts the fill at once
    ip = 32'h0000_5000; ihit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ihit = 1'b1;
    chk("rstfill_req", mem_req, 1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstfill_adr", mem_adr, 32'h0000_5020);
    #2 rst = 1'b1;
    #1;
    for (int w = 0; w < WAYS; w++) valid_m[w] = '0;
    chk("async_req", mem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_tag_wr", tag_wr, 0);
    chk("async_mem_adr", mem_adr, 0);
    chk_valid();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_tag_wr", tag_wr, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
